// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide run on |operands|; sign is fixed up in a final cycle.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        div0_q, div0_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [63:0] mul_res;

    always_comb begin
        signed_op = ~op[0];
        a_abs     = (signed_op && operand_a[31]) ? -operand_a : operand_a;
        b_abs     = (signed_op && operand_b[31]) ? -operand_b : operand_b;

        // Multiply: lo holds the remaining multiplier bits, product shifts in from the top.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ge    = (div_diff[33:32] == 2'b00);

        mul_res   = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = hilo_wdata;
                    else          lo_d = hilo_wdata;
                end
                if (start) begin
                    is_div_d  = op[1];
                    div0_d    = (operand_b == 32'd0);
                    neg_res_d = signed_op & (operand_a[31] ^ operand_b[31]);
                    neg_rem_d = signed_op & operand_a[31];
                    opb_d     = op[1] ? b_abs : a_abs;
                    acc_lo_d  = op[1] ? a_abs : b_abs;
                    acc_hi_d  = 32'd0;
                    cnt_d     = 6'd0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff[31:0] : div_shift[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = mul_res[63:32];
                    lo_d = mul_res[31:0];
                end else if (!div0_q) begin
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule
